// File: rtl/vip_framer_pkg.sv
// Shared types and constants for the Avalon-ST Video packet framer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package vip_framer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CTRL_HDR  = 3'd1,
      ST_CTRL_DATA = 3'd2,
      ST_IMG_HDR   = 3'd3,
      ST_IMG_DATA  = 3'd4
   } state_t;

   localparam logic [3:0] CTRL_PKT_TYPE = 4'hF;
   localparam logic [3:0] IMG_PKT_TYPE  = 4'h0;
   localparam int         CTRL_BEATS    = 9;

   typedef struct packed {
      logic [15:0] width;
      logic [15:0] height;
      logic [3:0]  interlace;
   } ctrl_hdr_t;

   // Control packet payload: width and height nibbles MSB first, then interlace.
   function automatic logic [3:0] ctrl_nibble(input ctrl_hdr_t c, input logic [3:0] idx);
      logic [3:0] n;
      n = 4'h0;
      case (idx)
         4'd0:    n = c.width[15:12];
         4'd1:    n = c.width[11:8];
         4'd2:    n = c.width[7:4];
         4'd3:    n = c.width[3:0];
         4'd4:    n = c.height[15:12];
         4'd5:    n = c.height[11:8];
         4'd6:    n = c.height[7:4];
         4'd7:    n = c.height[3:0];
         4'd8:    n = c.interlace;
         default: n = 4'h0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vip_raster_counter.sv
// Raster x/y position tracker; flags the final pixel of a WxH frame.
// Latency: last is combinational from the registered x/y position.
// Backpressure: position moves only on advance (an accepted pixel); clear restarts at 0,0.
module vip_raster_counter #(
   parameter int WIDTH_BITS  = 16,
   parameter int HEIGHT_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clear,
   input  logic                   advance,
   input  logic [WIDTH_BITS-1:0]  width,
   input  logic [HEIGHT_BITS-1:0] height,
   output logic                   last
);

   logic [WIDTH_BITS-1:0]  x;
   logic [HEIGHT_BITS-1:0] y;
   logic                   x_end;
   logic                   y_end;

   assign x_end = (x == width - WIDTH_BITS'(1));
   assign y_end = (y == height - HEIGHT_BITS'(1));
   assign last  = x_end & y_end;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         x <= '0;
         y <= '0;
      end else if (advance) begin
         if (x_end) begin
            x <= '0;
            y <= y_end ? '0 : y + HEIGHT_BITS'(1);
         end else begin
            x <= x + WIDTH_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/vip_packet_framer.sv
// Frames raw pixels into Avalon-ST Video packets (control packet only with VIP_FRAMER_CTRL_PKT_EN).
// Latency: header/control beats registered-state driven; pixels pass through combinationally.
// Backpressure: int_ready stalls every beat; pix_ready follows int_ready during the image payload.
module vip_packet_framer
   import vip_framer_pkg::*;
#(
   parameter int DATA_WIDTH  = 10,
   parameter int WIDTH_BITS  = 16,
   parameter int HEIGHT_BITS = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enable,
   input  logic [WIDTH_BITS-1:0]  cfg_width,
   input  logic [HEIGHT_BITS-1:0] cfg_height,
   input  logic [3:0]             cfg_interlace,
   input  logic                   pix_valid,
   input  logic [DATA_WIDTH-1:0]  pix_data,
   output logic                   pix_ready,
   input  logic                   int_ready,
   output logic                   int_valid,
   output logic [DATA_WIDTH-1:0]  int_data,
   output logic                   int_sop,
   output logic                   int_eop,
   output logic                   busy,
   output logic                   frame_done,
   output logic                   cfg_error
);

   state_t                 state, state_nxt;
   logic [WIDTH_BITS-1:0]  width_q;
   logic [HEIGHT_BITS-1:0] height_q;
   logic                   start;
   logic                   refuse;
   logic                   pix_xfer;
   logic                   last_pix;
   logic                   img_done;

`ifdef VIP_FRAMER_CTRL_PKT_EN
   localparam state_t FIRST_STATE = ST_CTRL_HDR;
   logic [3:0] interlace_q;
   logic [3:0] beat_q;
   logic       beat_last;
   ctrl_hdr_t  ctrl_hdr;

   assign ctrl_hdr  = '{width: 16'(width_q), height: 16'(height_q), interlace: interlace_q};
   assign beat_last = (beat_q == 4'(CTRL_BEATS - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         interlace_q <= '0;
         beat_q      <= '0;
      end else if (start) begin
         interlace_q <= cfg_interlace;
         beat_q      <= '0;
      end else if (state == ST_CTRL_DATA && int_ready) begin
         beat_q <= beat_last ? '0 : beat_q + 4'd1;
      end
   end
`else
   localparam state_t FIRST_STATE = ST_IMG_HDR;
   logic unused_interlace;
   assign unused_interlace = ^cfg_interlace;
`endif

   assign busy     = (state != ST_IDLE);
   assign pix_xfer = (state == ST_IMG_DATA) && pix_valid && int_ready;
   assign img_done = pix_xfer && last_pix;

   vip_raster_counter #(
      .WIDTH_BITS  (WIDTH_BITS),
      .HEIGHT_BITS (HEIGHT_BITS)
   ) u_raster (
      .clk     (clk),
      .rst     (rst),
      .clear   (start),
      .advance (pix_xfer),
      .width   (width_q),
      .height  (height_q),
      .last    (last_pix)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         width_q    <= '0;
         height_q   <= '0;
         frame_done <= 1'b0;
         cfg_error  <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= img_done;
         if (start) begin
            width_q  <= cfg_width;
            height_q <= cfg_height;
         end
         if (refuse) cfg_error <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      int_valid = 1'b0;
      int_data  = '0;
      int_sop   = 1'b0;
      int_eop   = 1'b0;
      pix_ready = 1'b0;
      start     = 1'b0;
      refuse    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (enable) begin
               if (cfg_width != '0 && cfg_height != '0) begin
                  start     = 1'b1;
                  state_nxt = FIRST_STATE;
               end else begin
                  refuse = 1'b1;
               end
            end
         end
`ifdef VIP_FRAMER_CTRL_PKT_EN
         ST_CTRL_HDR: begin
            int_valid = 1'b1;
            int_sop   = 1'b1;
            int_data  = DATA_WIDTH'(CTRL_PKT_TYPE);
            if (int_ready) state_nxt = ST_CTRL_DATA;
         end
         ST_CTRL_DATA: begin
            int_valid = 1'b1;
            int_data  = DATA_WIDTH'(ctrl_nibble(ctrl_hdr, beat_q));
            int_eop   = beat_last;
            if (int_ready && beat_last) state_nxt = ST_IMG_HDR;
         end
`endif
         ST_IMG_HDR: begin
            int_valid = 1'b1;
            int_sop   = 1'b1;
            int_data  = DATA_WIDTH'(IMG_PKT_TYPE);
            if (int_ready) state_nxt = ST_IMG_DATA;
         end
         ST_IMG_DATA: begin
            int_valid = pix_valid;
            int_data  = pix_data;
            pix_ready = int_ready;
            int_eop   = pix_valid && last_pix;
            if (img_done) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
